// File: rtl/kp_pad_pkg.sv
// Shared types and constants for the PC-FX K-port pad responder.
`timescale 1ns/1ps
package kp_pad_pkg;

  localparam logic [3:0]  KP_ID_PAD     = 4'hF;
  localparam int unsigned KP_FRAME_BITS = 32;
  localparam int unsigned KP_CNT_W      = 6;
  localparam int unsigned KP_BTN_W      = 16;

  // Bit positions of each button inside BUTTONS and the low half of a frame.
  typedef enum logic [3:0] {
    KP_BTN_I      = 4'd0,
    KP_BTN_II     = 4'd1,
    KP_BTN_III    = 4'd2,
    KP_BTN_IV     = 4'd3,
    KP_BTN_V      = 4'd4,
    KP_BTN_VI     = 4'd5,
    KP_BTN_SELECT = 4'd6,
    KP_BTN_RUN    = 4'd7,
    KP_BTN_UP     = 4'd8,
    KP_BTN_RIGHT  = 4'd9,
    KP_BTN_DOWN   = 4'd10,
    KP_BTN_LEFT   = 4'd11,
    KP_BTN_MODE1  = 4'd12,
    KP_BTN_RSV13  = 4'd13,
    KP_BTN_MODE2  = 4'd14,
    KP_BTN_RSV15  = 4'd15
  } kp_btn_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DONE   = 2'd3
  } kp_state_e;

endpackage

// File: rtl/kp_pad_if.sv
// K-port host link: latch/clock/direction/data from the host, serial data back.
// master = host side (drives strobes), slave = pad side (drives KP_DIN).
`timescale 1ns/1ps
interface kp_pad_if;
  logic KP_LATCH;
  logic KP_CLK;
  logic KP_RW;
  logic KP_DOUT;
  logic KP_DIN;

  modport master (output KP_LATCH, KP_CLK, KP_RW, KP_DOUT, input KP_DIN);
  modport slave  (input KP_LATCH, KP_CLK, KP_RW, KP_DOUT, output KP_DIN);
endinterface

// File: rtl/kp_pad_sync.sv
// Multi-stage synchroniser with a rising-edge pulse taken from the last stage.
// Ports: CLK/RES core clock and async reset; d async input; q synchronised level;
//        rise_c one-CLK pulse in the cycle q first reads 1.
`timescale 1ns/1ps
module kp_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic CLK,
  input  logic RES,
  input  logic d,
  output logic q,
  output logic rise_c
);

  logic [STAGES-1:0] chain;
  logic              q_d;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      chain <= '0;
      q_d   <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
    end
  end

  assign q      = chain[STAGES-1];
  assign rise_c = chain[STAGES-1] & ~q_d;

endmodule

// File: rtl/kp_pad.sv
// PC-FX joypad responder on one K-port channel: serialises the pad frame to the
// host (LSB first) and deserialises host writes.
// Ports: CLK/RES core clock and async reset; CONNECTED pad present; BUTTONS
//        pressed map; kp host link (slave); RX_DATA last written word;
//        RX_VALID one-CLK pulse when RX_DATA updates.
`timescale 1ns/1ps
module kp_pad
  import kp_pad_pkg::*;
#(
  parameter logic [3:0]  PAD_ID      = KP_ID_PAD,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = KP_FRAME_BITS
) (
  input  logic                  CLK,
  input  logic                  RES,
  input  logic                  CONNECTED,
  input  logic [KP_BTN_W-1:0]   BUTTONS,
  kp_pad_if.slave               kp,
  output logic [FRAME_BITS-1:0] RX_DATA,
  output logic                  RX_VALID
);

  logic latch_q, latch_rise, clk_rise, rw_q, dout_q;
  logic clk_lvl_unused, rw_rise_unused, dout_rise_unused;

  kp_sync #(.STAGES(SYNC_STAGES)) u_sync_latch (
    .CLK(CLK), .RES(RES), .d(kp.KP_LATCH), .q(latch_q), .rise_c(latch_rise));
  kp_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .CLK(CLK), .RES(RES), .d(kp.KP_CLK), .q(clk_lvl_unused), .rise_c(clk_rise));
  kp_sync #(.STAGES(SYNC_STAGES)) u_sync_rw (
    .CLK(CLK), .RES(RES), .d(kp.KP_RW), .q(rw_q), .rise_c(rw_rise_unused));
  kp_sync #(.STAGES(SYNC_STAGES)) u_sync_dout (
    .CLK(CLK), .RES(RES), .d(kp.KP_DOUT), .q(dout_q), .rise_c(dout_rise_unused));

  kp_state_e             state, state_n;
  logic [FRAME_BITS-1:0] tx_sr, tx_sr_n;
  logic [FRAME_BITS-1:0] rx_sr, rx_sr_n;
  logic [KP_CNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [FRAME_BITS-1:0] rx_data_n;
  logic                  rx_valid_n;
  logic                  din_n;
  logic [FRAME_BITS-1:0] frame_c;
  logic                  shift_ok_c;

  assign frame_c = CONNECTED ? FRAME_BITS'({PAD_ID, 12'h000, BUTTONS}) : '1;

  // The first host clock in LOADED already moves a bit, so 32 edges cover a frame.
  assign shift_ok_c = clk_rise & ~latch_q &
                      ((state == ST_LOADED) || (state == ST_SHIFT));

  // Next-state and datapath; a latch edge always wins over a coincident clock edge.
  always_comb begin
    state_n    = state;
    tx_sr_n    = tx_sr;
    rx_sr_n    = rx_sr;
    bit_cnt_n  = bit_cnt;
    rx_data_n  = RX_DATA;
    rx_valid_n = 1'b0;
    if (latch_rise) begin
      state_n   = ST_LOADED;
      tx_sr_n   = frame_c;
      rx_sr_n   = '0;
      bit_cnt_n = '0;
    end else if (shift_ok_c) begin
      state_n = ST_SHIFT;
      if (rw_q) begin
        rx_sr_n = {dout_q, rx_sr[FRAME_BITS-1:1]};
      end else begin
        tx_sr_n = {1'b1, tx_sr[FRAME_BITS-1:1]};
      end
      bit_cnt_n = bit_cnt + KP_CNT_W'(1);
      if (bit_cnt_n == KP_CNT_W'(FRAME_BITS)) begin
        state_n = ST_DONE;
        if (rw_q && CONNECTED) begin
          rx_data_n  = rx_sr_n;
          rx_valid_n = 1'b1;
        end
      end
    end
    din_n = ((state_n == ST_LOADED) || (state_n == ST_SHIFT)) ? tx_sr_n[0] : 1'b1;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state     <= ST_IDLE;
      tx_sr     <= '1;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      RX_DATA   <= '0;
      RX_VALID  <= 1'b0;
      kp.KP_DIN <= 1'b1;
    end else begin
      state     <= state_n;
      tx_sr     <= tx_sr_n;
      rx_sr     <= rx_sr_n;
      bit_cnt   <= bit_cnt_n;
      RX_DATA   <= rx_data_n;
      RX_VALID  <= rx_valid_n;
      kp.KP_DIN <= din_n;
    end
  end

endmodule

// File: tb/tb_kp_pad.sv
// Self-checking bench for kp_pad: directed host sequences plus randomised frames
// checked against a word-level model of the pad.
`timescale 1ns/1ps
module tb_kp_pad;
  import kp_pad_pkg::*;

  localparam int unsigned HOLD = 6;

  logic        CLK = 1'b0;
  logic        RES;
  logic        CONNECTED;
  logic [15:0] BUTTONS;
  logic [31:0] RX_DATA;
  logic        RX_VALID;

  kp_pad_if kp();

  kp_pad dut (
    .CLK       (CLK),
    .RES       (RES),
    .CONNECTED (CONNECTED),
    .BUTTONS   (BUTTONS),
    .kp        (kp),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID)
  );

  always #5 CLK = ~CLK;

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;
  int unsigned vcnt   = 0;

  always @(negedge CLK) if (RX_VALID === 1'b1) vcnt++;

  function automatic logic [31:0] frame_of(logic conn, logic [15:0] btn);
    return conn ? {4'hF, 12'h000, btn} : 32'hFFFF_FFFF;
  endfunction

  task automatic wait_clk(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic host_latch();
    kp.KP_LATCH = 1'b1; wait_clk(HOLD);
    kp.KP_LATCH = 1'b0; wait_clk(HOLD);
  endtask

  task automatic host_pulse();
    kp.KP_CLK = 1'b1; wait_clk(HOLD);
    kp.KP_CLK = 1'b0; wait_clk(HOLD);
  endtask

  // Sample KP_DIN, then clock one read edge.
  task automatic read_bit(output logic b);
    b = kp.KP_DIN;
    kp.KP_RW = 1'b0; wait_clk(3);
    host_pulse();
  endtask

  task automatic write_bit(input logic b);
    kp.KP_RW = 1'b1; kp.KP_DOUT = b; wait_clk(3);
    host_pulse();
  endtask

  task automatic read_word(input int n, output logic [31:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < n; i++) begin
      read_bit(b);
      w[i] = b;
    end
  endtask

  task automatic write_word(input int n, input logic [31:0] w);
    for (int i = 0; i < n; i++) write_bit(w[i]);
  endtask

  initial begin
    logic [31:0] w, exp_rx, fr, rd_exp, rd_got, rx_model;
    logic        b, conn, last_wr;
    int unsigned v0, nrd, mode;

    RES = 1'b1; CONNECTED = 1'b1; BUTTONS = '0;
    kp.KP_LATCH = 1'b0; kp.KP_CLK = 1'b0; kp.KP_RW = 1'b0; kp.KP_DOUT = 1'b0;
    exp_rx = '0;
    wait_clk(3);
    check("reset_din", 32'(kp.KP_DIN), 32'd1);
    check("reset_rx_data", RX_DATA, 32'd0);
    check("reset_rx_valid", 32'(RX_VALID), 32'd0);
    RES = 1'b0;

    // Idle: nothing happens over a long stretch.
    wait_clk(1000);
    check("idle_din", 32'(kp.KP_DIN), 32'd1);
    check("idle_no_valid", vcnt, 32'd0);

    // Plain read of a connected pad, plus the ignored 33rd edge.
    BUTTONS = 16'h0005;
    host_latch();
    read_word(32, w);
    check("read_0005", w, frame_of(1'b1, 16'h0005));
    check("din_after_32", 32'(kp.KP_DIN), 32'd1);
    read_bit(b);
    check("din_after_33", 32'(kp.KP_DIN), 32'd1);
    check("read_no_valid", vcnt, 32'd0);

    // Disconnected pad reads all-ones and ignores writes.
    CONNECTED = 1'b0;
    host_latch();
    read_word(32, w);
    check("disc_read", w, 32'hFFFF_FFFF);
    v0 = vcnt;
    host_latch();
    write_word(32, 32'h1234_5678);
    check("disc_write_no_valid", vcnt - v0, 32'd0);
    check("disc_write_rx_data", RX_DATA, exp_rx);

    // Full write to a connected pad.
    CONNECTED = 1'b1;
    v0 = vcnt;
    host_latch();
    write_word(32, 32'hA5A5_0F0F);
    exp_rx = 32'hA5A5_0F0F;
    check("write_one_valid", vcnt - v0, 32'd1);
    check("write_rx_data", RX_DATA, exp_rx);
    check("write_din_done", 32'(kp.KP_DIN), 32'd1);

    // Re-latch mid-frame with new buttons restarts from bit 0.
    BUTTONS = 16'h0005;
    host_latch();
    read_word(10, w);
    check("partial_10", w & 32'h3FF, frame_of(1'b1, 16'h0005) & 32'h3FF);
    BUTTONS = 16'h8000;
    host_latch();
    read_word(32, w);
    check("relatch_8000", w, frame_of(1'b1, 16'h8000));

    // Latch and clock rising together: the clock edge must not shift.
    host_latch();
    read_word(3, w);
    kp.KP_RW = 1'b0;
    kp.KP_LATCH = 1'b1; kp.KP_CLK = 1'b1; wait_clk(HOLD);
    kp.KP_LATCH = 1'b0; kp.KP_CLK = 1'b0; wait_clk(HOLD);
    read_word(32, w);
    check("latch_clk_same", w, frame_of(1'b1, 16'h8000));

    // Clock edge while latch is held high is ignored.
    BUTTONS = 16'h1234;
    kp.KP_LATCH = 1'b1; wait_clk(HOLD);
    host_pulse();
    kp.KP_LATCH = 1'b0; wait_clk(HOLD);
    read_word(32, w);
    check("clk_during_latch", w, frame_of(1'b1, 16'h1234));

    // Reset in the middle of a write frame.
    v0 = vcnt;
    host_latch();
    write_word(20, $urandom);
    RES = 1'b1; wait_clk(2);
    exp_rx = '0;
    check("midreset_din", 32'(kp.KP_DIN), 32'd1);
    check("midreset_rx_data", RX_DATA, exp_rx);
    RES = 1'b0; wait_clk(HOLD);
    read_word(4, w);
    check("postreset_din_idle", w & 32'hF, 32'hF);
    check("midreset_no_valid", vcnt - v0, 32'd0);
    BUTTONS = 16'h0005;
    host_latch();
    read_word(32, w);
    check("postreset_read", w, frame_of(1'b1, 16'h0005));
    check("postreset_din_done", 32'(kp.KP_DIN), 32'd1);

    // Randomised frames: all-read, all-write, or mixed direction per bit.
    for (int it = 0; it < 9; it++) begin
      mode = it % 3;
      conn = ($urandom_range(0, 3) != 0);
      CONNECTED = conn;
      BUTTONS = 16'($urandom);
      fr = frame_of(conn, BUTTONS);
      host_latch();
      v0 = vcnt; nrd = 0; rx_model = '0; rd_got = '0; last_wr = 1'b0;
      for (int k = 0; k < 32; k++) begin
        if (k == 16) BUTTONS = ~BUTTONS;
        last_wr = (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1);
        if (last_wr) begin
          b = 1'($urandom);
          write_bit(b);
          rx_model = (rx_model >> 1) | (32'(b) << 31);
        end else begin
          read_bit(b);
          rd_got[nrd] = b;
          nrd++;
        end
      end
      rd_exp = (nrd == 32) ? fr : (fr & ((32'd1 << nrd) - 32'd1));
      check($sformatf("rand%0d_read", it), rd_got, rd_exp);
      if (last_wr && conn) exp_rx = rx_model;
      check($sformatf("rand%0d_valid", it), vcnt - v0, (last_wr && conn) ? 32'd1 : 32'd0);
      check($sformatf("rand%0d_rx_data", it), RX_DATA, exp_rx);
      check($sformatf("rand%0d_din", it), 32'(kp.KP_DIN), 32'd1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
